// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 read-data collector.
package mpmc11_pkg;

    localparam int RD_LEN_W   = 6;  // burst length field, lines minus one
    localparam int LINE_CNT_W = 7;  // one wider than RD_LEN_W so 64 lines never wrap
    localparam int CHAN_W     = 4;  // channel tag width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } mpmc11_rdc_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpmc11_rdc_fifo.sv
// Output FIFO for assembled lines: {last, chan, line}. Head is read combinationally
// from storage so it stays stable while not popped.
module mpmc11_rdc_fifo
    import mpmc11_pkg::*;
#(
    parameter int W     = 261,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_pop,
    output logic         o_drop,
    output logic         o_empty_next
);

    localparam int AW = clog2_min1(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [AW:0]   w_count_nxt;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_rd_ptr_nxt;

    // Push/pop qualification; a push into a full FIFO only lands if a pop frees a slot.
    always_comb begin
        w_full       = (r_count == (AW+1)'(DEPTH));
        w_pop        = i_pop && (r_count != '0);
        w_wr         = i_push && (!w_full || w_pop);
        w_count_nxt  = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
        w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
    end

    assign o_data       = r_mem[r_rd_ptr];
    assign o_valid      = (r_count != '0);
    assign o_pop        = w_pop;
    assign o_drop       = i_push && w_full && !w_pop;
    assign o_empty_next = (w_count_nxt == '0);

    // Storage, pointers and occupancy; reset clears storage so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (w_pop) r_rd_ptr <= w_rd_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/mpmc11_rd_data_collect.sv
// Collects memory read beats into WID-wide lines, tags them with the burst's channel
// and last flag, and queues them for the consumer.
module mpmc11_rd_data_collect
    import mpmc11_pkg::*;
#(
    parameter int WID   = 256,
    parameter int BEAT  = 128,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_start,
    input  logic [CHAN_W-1:0]   rd_chan,
    input  logic [RD_LEN_W-1:0] rd_len,
    input  logic                app_rd_data_valid,
    input  logic [BEAT-1:0]     app_rd_data,
    output logic [WID-1:0]      dato,
    output logic [CHAN_W-1:0]   dato_chan,
    output logic                dato_last,
    output logic                dato_valid,
    input  logic                dato_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int NB  = WID / BEAT;
    localparam int BCW = clog2_min1(NB);
    localparam int EW  = 1 + CHAN_W + WID;

    mpmc11_rdc_state_t     r_state;
    logic [CHAN_W-1:0]     r_chan;
    logic [RD_LEN_W-1:0]   r_len;
    logic [BCW-1:0]        r_beat;
    logic [LINE_CNT_W-1:0] r_line;
    logic [WID-1:0]        r_acc;
    logic                  r_overrun;

    logic                  w_beat_in;
    logic                  w_line_done;
    logic                  w_last;
    logic [WID-1:0]        w_line;
    logic [EW-1:0]         w_head;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_empty_next;

    // Final beat goes straight into the line so it can be pushed in the same cycle.
    always_comb begin
        w_line = r_acc;
        w_line[(NB-1)*BEAT +: BEAT] = app_rd_data;
        w_beat_in   = (r_state == ST_COLLECT) && app_rd_data_valid;
        w_line_done = w_beat_in && (r_beat == BCW'(NB-1));
        w_last      = (r_line == {1'b0, r_len});
    end

    mpmc11_rdc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_line_done),
        .i_data       ({w_last, r_chan, w_line}),
        .i_pop        (dato_ready),
        .o_data       (w_head),
        .o_valid      (dato_valid),
        .o_pop        (w_pop),
        .o_drop       (w_drop),
        .o_empty_next (w_empty_next)
    );

    assign dato      = w_head[WID-1:0];
    assign dato_chan = w_head[WID +: CHAN_W];
    assign dato_last = w_head[EW-1];
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;

    // Burst FSM: beat/line counting and partial-line accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_chan  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_line  <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_start) begin
                        r_chan  <= rd_chan;
                        r_len   <= rd_len;
                        r_beat  <= '0;
                        r_line  <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_line_done) begin
                        // Counters advance even if the FIFO drops the line.
                        r_beat <= '0;
                        r_line <= r_line + 1'b1;
                        if (w_last) r_state <= ST_DRAIN;
                    end else if (w_beat_in) begin
                        r_acc[int'(r_beat)*BEAT +: BEAT] <= app_rd_data;
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave as the last queued line is popped, so busy drops right after.
                    if (w_empty_next) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error: stray beats outside COLLECT, or a line dropped on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if ((app_rd_data_valid && (r_state != ST_COLLECT)) || w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = w_pop;

endmodule

// File: tb/tb_mpmc11_rd_data_collect.sv
// Directed bench for the read-data collector with a scoreboard of expected lines.
module tb_mpmc11_rd_data_collect;
    import mpmc11_pkg::*;

    localparam int WID  = 256;
    localparam int BEAT = 128;
    localparam int NB   = WID / BEAT;
    localparam int EW   = 1 + CHAN_W + WID;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rd_start;
    logic [CHAN_W-1:0]   rd_chan;
    logic [RD_LEN_W-1:0] rd_len;
    logic                app_rd_data_valid;
    logic [BEAT-1:0]     app_rd_data;
    logic [WID-1:0]      dato;
    logic [CHAN_W-1:0]   dato_chan;
    logic                dato_last;
    logic                dato_valid;
    logic                dato_ready;
    logic                busy;
    logic                overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] sb[$];

    mpmc11_rd_data_collect #(.WID(WID), .BEAT(BEAT), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_chan(rd_chan), .rd_len(rd_len),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .dato(dato), .dato_chan(dato_chan), .dato_last(dato_last), .dato_valid(dato_valid),
        .dato_ready(dato_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the head line whenever the consumer accepts it.
    logic [EW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && dato_valid && dato_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_line_cnt", EW'(sb.size()), EW'(1));
            end else begin
                mon_exp = sb.pop_front();
                chk("line", {dato_last, dato_chan, dato}, mon_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic start(input logic [CHAN_W-1:0] ch, input logic [RD_LEN_W-1:0] len);
        rd_start = 1'b1; rd_chan = ch; rd_len = len;
        cyc();
        rd_start = 1'b0;
    endtask

    task automatic beat(input logic [BEAT-1:0] d, input logic rdy);
        app_rd_data_valid = 1'b1; app_rd_data = d; dato_ready = rdy;
        cyc();
        app_rd_data_valid = 1'b0;
    endtask

    task automatic send_line(input logic [WID-1:0] l, input logic rdy_last, input logic rdy_other);
        for (int k = 0; k < NB; k++)
            beat(l[k*BEAT +: BEAT], (k == NB-1) ? rdy_last : rdy_other);
    endtask

    function automatic logic [WID-1:0] rand_line();
        logic [WID-1:0] v;
        for (int i = 0; i < WID/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) cyc();
        chk("drain_left", EW'(sb.size()), EW'(0));
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_dato"}, EW'(dato), EW'(0));
        chk({tag, "_chan"}, EW'(dato_chan), EW'(0));
        chk1({tag, "_last"}, dato_last, 1'b0);
        chk1({tag, "_valid"}, dato_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_overrun"}, overrun, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        cyc();
    endtask

    logic [WID-1:0] ln [6];
    logic [WID-1:0] l1;

    initial begin
        rst_n = 1'b0; rd_start = 0; rd_chan = 0; rd_len = 0;
        app_rd_data_valid = 0; app_rd_data = '0; dato_ready = 0;
        #12;
        chk_rst("reset");
        @(negedge clk) rst_n = 1'b1;
        cyc();

        // Single line, chan 3, len 0.
        l1 = {{32{4'hB}}, {32{4'hA}}};
        sb.push_back({1'b1, 4'd3, l1});
        start(4'd3, 6'd0);
        beat({32{4'hA}}, 1'b0);
        beat({32{4'hB}}, 1'b0);
        chk1("t1_valid", dato_valid, 1'b1);
        chk("t1_dato", EW'(dato), EW'(l1));
        chk("t1_chan", EW'(dato_chan), EW'(3));
        chk1("t1_last", dato_last, 1'b1);
        chk1("t1_busy_before_pop", busy, 1'b1);
        dato_ready = 1'b1;
        cyc();
        dato_ready = 1'b0;
        chk1("t1_busy_after_pop", busy, 1'b0);
        chk1("t1_valid_after_pop", dato_valid, 1'b0);

        // Four-line burst, consumer always ready, back-to-back beats.
        for (int i = 0; i < 4; i++) begin
            ln[i] = rand_line();
            sb.push_back({(i == 3), 4'd7, ln[i]});
        end
        start(4'd7, 6'd3);
        for (int i = 0; i < 4; i++) send_line(ln[i], 1'b1, 1'b1);
        wait_drain(20);
        chk1("t2_overrun", overrun, 1'b0);
        chk1("t2_busy", busy, 1'b0);
        dato_ready = 1'b0;

        // Overflow: 6 lines into a 4-deep FIFO with no consumer.
        for (int i = 0; i < 6; i++) begin
            ln[i] = rand_line();
            if (i < 4) sb.push_back({1'b0, 4'd12, ln[i]});
        end
        start(4'd12, 6'd5);
        for (int i = 0; i < 4; i++) send_line(ln[i], 1'b0, 1'b0);
        chk1("t3_overrun_at_full", overrun, 1'b0);
        for (int i = 4; i < 6; i++) send_line(ln[i], 1'b0, 1'b0);
        chk1("t3_overrun", overrun, 1'b1);
        chk1("t3_busy", busy, 1'b1);
        chk1("t3_valid", dato_valid, 1'b1);
        dato_ready = 1'b1;
        wait_drain(20);
        dato_ready = 1'b0;
        chk1("t3_busy_after", busy, 1'b0);
        chk1("t3_valid_after", dato_valid, 1'b0);
        do_reset();

        // Push and pop together while full.
        for (int i = 0; i < 5; i++) begin
            ln[i] = rand_line();
            sb.push_back({(i == 4), 4'd5, ln[i]});
        end
        start(4'd5, 6'd4);
        for (int i = 0; i < 4; i++) send_line(ln[i], 1'b0, 1'b0);
        send_line(ln[4], 1'b1, 1'b0);
        dato_ready = 1'b0;
        chk1("t4_overrun", overrun, 1'b0);
        chk1("t4_valid", dato_valid, 1'b1);
        chk("t4_sb_left", EW'(sb.size()), EW'(4));
        dato_ready = 1'b1;
        wait_drain(20);
        dato_ready = 1'b0;
        chk1("t4_valid_after", dato_valid, 1'b0);
        chk1("t4_busy_after", busy, 1'b0);

        // Stray beat while idle.
        beat(128'h1234, 1'b0);
        chk1("t5_overrun", overrun, 1'b1);
        chk1("t5_valid", dato_valid, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        do_reset();

        // Reset in the middle of an 8-beat burst.
        start(4'd9, 6'd3);
        for (int i = 0; i < 3; i++) beat(BEAT'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_rst("t6_midrst");
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        cyc();
        l1 = rand_line();
        sb.push_back({1'b1, 4'd10, l1});
        start(4'd10, 6'd0);
        send_line(l1, 1'b1, 1'b1);
        wait_drain(10);
        dato_ready = 1'b0;
        chk1("t6_overrun", overrun, 1'b0);
        chk1("t6_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
